mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Parametrised RV32M/RV64M execution unit: multiply (pipelined latency), divide/remainder (iterative radix-2, one quotient bit per cycle).
- Sits beside the integer ALU and is fed by its own reservation-station slot.
- Writes one tagged result to the CDB with a hold-until-granted handshake. The integer ALU has no such handshake.
- Supports flush on branch mispredict.
- Single operation in flight.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- TAG_W, 4, ROB tag width (matches ROB_BIT).
- MUL_STAGES, 2, multiply latency in cycles, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  global stall-enable; low freezes all state and outputs
- clear_i  in  1  flush; aborts in-flight op, drops any pending result
- rs_en_i  in  1  issue request from RS
- rs_op_i  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs_qd_i  in  TAG_W  destination ROB tag
- rs_vs_i  in  XLEN  rs1 value
- rs_vt_i  in  XLEN  rs2 value
- rs_rdy_o  out  1  unit can accept (combinational: state==IDLE)
- cdb_en_o  out  1  result valid
- cdb_q_o  out  TAG_W  result tag
- cdb_v_o  out  XLEN  result value
- cdb_gnt_i  in  1  CDB arbiter grant

Behaviour:
- Reset (async): state IDLE, counters 0, cdb_en_o=0, cdb_q_o=0, cdb_v_o=0. rs_rdy_o=1 after reset.
- States: IDLE, MUL, DIV, DONE. All transitions require en=1 at the posedge; en=0 holds everything.
- Accept:
  - Occurs at a posedge with rs_en_i && rs_rdy_o && en && !clear_i.
  - Latch tag and op.
  - op<4 -> MUL. op>=4 -> DIV, or straight to DONE on a special case.
  - rs_en_i while not ready is ignored; the RS must hold its request.
- MUL path:
  - At accept, form a 2*XLEN product from operands extended per op: MUL/MULHU unsigned x unsigned; MULH signed x signed; MULHSU signed rs1 x unsigned rs2.
  - Carry it through MUL_STAGES-1 further delay registers.
  - Result: MUL = low XLEN bits; MULH, MULHSU, MULHU = high XLEN bits.
  - cdb_en_o rises after posedge k+MUL_STAGES, where k is the accept edge.
- DIV path:
  - At accept, latch |rs1| and |rs2| (signed ops) or raw values (unsigned ops). Record quotient sign = sign1^sign2 and remainder sign = sign1.
  - Load counter with XLEN.
  - Each cycle, one restoring shift-subtract step; the counter decrements.
  - The edge after the counter reaches 0 applies sign correction and enters DONE.
  - cdb_en_o rises after edge k+XLEN+1.
- Special cases (resolved at accept, DONE after edge k+1):
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): DIV -> rs1; REM -> 0.
- DONE:
  - cdb_en_o=1; cdb_q_o and cdb_v_o stable until granted.
  - At a posedge with cdb_gnt_i && en: go to IDLE and drive cdb_en_o=0.
  - rs_rdy_o goes high the cycle after the grant; no accept in the grant cycle.
  - cdb_gnt_i outside DONE is ignored.
- clear_i:
  - At a posedge with en=1 and clear_i=1, go to IDLE from any state and drop cdb_en_o the next cycle.
  - Takes priority over accept and grant in the same cycle.
  - clear_i with en=0 is ignored.
- cdb_q_o and cdb_v_o are don't-care when cdb_en_o=0, but retain their last value (no X).
- Arithmetic wraps modulo 2^XLEN. Counter width is $clog2(XLEN+1).

Decomposition:
- Shared header/package:
  - funct3 op encodings (MDU_MUL..MDU_REMU).
  - State encoding.
  - XLEN/TAG_W defaults aligned with DAT_W/ROB_BIT.
- One natural sub-module: iter_divider. It owns the restoring loop, counter, sign fix-up and special-case detection, with start/done handshake and clear.
- The multiplier stays inline.

Test Plan:
- MUL 7 x -3 (rs1=7, rs2=0xFFFFFFFD), tag 5, MUL_STAGES=2 -> cdb_en_o after 2 edges, cdb_v_o=0xFFFFFFEB, cdb_q_o=5; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV -20/3 -> 0xFFFFFFFA after 33 edges; REM -20/3 -> 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0, each after 1 edge.
- Hold result with cdb_gnt_i=0 for 10 cycles -> cdb_en_o, tag and value unchanged, rs_rdy_o=0; grant -> cdb_en_o=0 next cycle, rs_rdy_o=1.
- clear_i mid-DIV at iteration 10 -> IDLE next edge, no cdb_en_o ever; immediate new MUL issue completes correctly. clear_i together with grant -> IDLE, no double result.
- en=0 for 5 cycles mid-DIV -> completion delayed exactly 5 cycles. Async rst asserted mid-MUL between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
// Holds the funct3 operation encodings, the FSM states and the default widths.
package mul_div_unit_pkg;

   localparam int DAT_W          = 32;
   localparam int ROB_BIT        = 4;
   localparam int MDU_MUL_STAGES = 2;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } mdu_state_e;

   // funct3 bit 2 separates the divide family from the multiply family
   function automatic logic op_is_div(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Reservation-station issue port and CDB result port of the multiply/divide unit.
// The slave modport is the unit itself; the master modport is its surroundings.
interface mul_div_unit_if
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN  = DAT_W,
   parameter int TAG_W = ROB_BIT
);

   logic             rs_en_i;
   logic [2:0]       rs_op_i;
   logic [TAG_W-1:0] rs_qd_i;
   logic [XLEN-1:0]  rs_vs_i;
   logic [XLEN-1:0]  rs_vt_i;
   logic             rs_rdy_o;

   logic             cdb_en_o;
   logic [TAG_W-1:0] cdb_q_o;
   logic [XLEN-1:0]  cdb_v_o;
   logic             cdb_gnt_i;

   modport slave (
      input  rs_en_i, rs_op_i, rs_qd_i, rs_vs_i, rs_vt_i, cdb_gnt_i,
      output rs_rdy_o, cdb_en_o, cdb_q_o, cdb_v_o
   );

   modport master (
      output rs_en_i, rs_op_i, rs_qd_i, rs_vs_i, rs_vt_i, cdb_gnt_i,
      input  rs_rdy_o, cdb_en_o, cdb_q_o, cdb_v_o
   );

endinterface

// File: rtl/mul_div_unit_iter_divider.sv
// Radix-2 restoring divider: one quotient bit per enabled cycle, then a sign fix-up cycle.
// Divide-by-zero and signed overflow are resolved at start and reported one cycle later.
module mul_div_unit_iter_divider
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN = DAT_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clear,
   input  logic            start,
   input  logic            is_signed,
   input  logic            is_rem,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   logic            active;
   logic            special;
   logic            neg_q;
   logic            neg_r;
   logic            rem_sel;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] special_val;

   logic            sign1;
   logic            sign2;
   logic            div_zero;
   logic            overflow;
   logic [XLEN-1:0] abs1;
   logic [XLEN-1:0] abs2;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;
   logic            fits;

   always_comb begin
      sign1    = is_signed & dividend[XLEN-1];
      sign2    = is_signed & divisor[XLEN-1];
      abs1     = sign1 ? -dividend : dividend;
      abs2     = sign2 ? -divisor : divisor;
      div_zero = (divisor == '0);
      overflow = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
      shifted  = {rem, quo[XLEN-1]};
      diff     = shifted - {1'b0, dvs};
      fits     = (shifted >= {1'b0, dvs});
      done     = active && (special || (cnt == '0));
      if (special)
         result = special_val;
      else if (rem_sel)
         result = neg_r ? -rem : rem;
      else
         result = neg_q ? -quo : quo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active      <= 1'b0;
         special     <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         rem_sel     <= 1'b0;
         cnt         <= '0;
         quo         <= '0;
         rem         <= '0;
         dvs         <= '0;
         special_val <= '0;
      end else if (en) begin
         if (clear) begin
            active <= 1'b0;
         end else if (start) begin
            active      <= 1'b1;
            special     <= div_zero || overflow;
            special_val <= div_zero ? (is_rem ? dividend : '1) : (is_rem ? '0 : dividend);
            quo         <= abs1;
            rem         <= '0;
            dvs         <= abs2;
            cnt         <= CW'(XLEN);
            neg_q       <= sign1 ^ sign2;
            neg_r       <= sign1;
            rem_sel     <= is_rem;
         end else if (done) begin
            active <= 1'b0;
         end else if (active) begin
            // quotient bits shift in where dividend bits shift out
            cnt <= cnt - 1'b1;
            quo <= {quo[XLEN-2:0], fits};
            rem <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
         end
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M/RV64M execution unit: pipelined multiplier inline, iterative divider as a sub-module.
// One operation in flight; the tagged result is held on the CDB until the arbiter grants it.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN       = DAT_W,
   parameter int TAG_W      = ROB_BIT,
   parameter int MUL_STAGES = MDU_MUL_STAGES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clear_i,
   mul_div_unit_if.slave   bus
);

   localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

   mdu_state_e        state;
   mdu_state_e        next_state;
   logic              accept;
   logic [TAG_W-1:0]  tag_q;
   logic [2:0]        op_q;
   logic [MCW-1:0]    mul_cnt;
   logic [TAG_W-1:0]  cdb_q;
   logic [XLEN-1:0]   cdb_v;

   logic [2*XLEN-1:0] a_ext;
   logic [2*XLEN-1:0] b_ext;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] pipe [MUL_STAGES];
   logic [2*XLEN-1:0] pipe_last;
   logic [XLEN-1:0]   mul_result;

   logic              div_done;
   logic [XLEN-1:0]   div_result;

   assign accept = en && !clear_i && bus.rs_en_i && (state == IDLE);

   // Extending both operands to 2*XLEN lets one unsigned multiply cover every signedness mix
   always_comb begin
      a_ext = ((bus.rs_op_i == MDU_MULH) || (bus.rs_op_i == MDU_MULHSU))
              ? {{XLEN{bus.rs_vs_i[XLEN-1]}}, bus.rs_vs_i} : {{XLEN{1'b0}}, bus.rs_vs_i};
      b_ext = (bus.rs_op_i == MDU_MULH)
              ? {{XLEN{bus.rs_vt_i[XLEN-1]}}, bus.rs_vt_i} : {{XLEN{1'b0}}, bus.rs_vt_i};
      prod       = a_ext * b_ext;
      pipe_last  = pipe[MUL_STAGES-1];
      mul_result = (op_q == MDU_MUL) ? pipe_last[XLEN-1:0] : pipe_last[2*XLEN-1:XLEN];
   end

   mul_div_unit_iter_divider #(
      .XLEN (XLEN)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clear     (clear_i),
      .start     (accept && op_is_div(bus.rs_op_i)),
      .is_signed (!bus.rs_op_i[0]),
      .is_rem    (bus.rs_op_i[1]),
      .dividend  (bus.rs_vs_i),
      .divisor   (bus.rs_vt_i),
      .done      (div_done),
      .result    (div_result)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else if (en)
         state <= next_state;
   end

   // Flush outranks both a new issue and a CDB grant
   always_comb begin
      next_state = state;
      if (clear_i) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.rs_en_i) next_state = op_is_div(bus.rs_op_i) ? DIV : MUL;
            MUL:  if (mul_cnt == '0) next_state = DONE;
            DIV:  if (div_done) next_state = DONE;
            DONE: if (bus.cdb_gnt_i) next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.rs_rdy_o = (state == IDLE);
      bus.cdb_en_o = (state == DONE);
      bus.cdb_q_o  = cdb_q;
      bus.cdb_v_o  = cdb_v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q   <= '0;
         op_q    <= '0;
         mul_cnt <= '0;
         cdb_q   <= '0;
         cdb_v   <= '0;
         for (int i = 0; i < MUL_STAGES; i++)
            pipe[i] <= '0;
      end else if (en) begin
         for (int i = 1; i < MUL_STAGES; i++)
            pipe[i] <= pipe[i-1];
         if (accept) begin
            tag_q   <= bus.rs_qd_i;
            op_q    <= bus.rs_op_i;
            mul_cnt <= MCW'(MUL_STAGES - 1);
            pipe[0] <= prod;
         end
         if (!clear_i) begin
            if (state == MUL) begin
               if (mul_cnt != '0) begin
                  mul_cnt <= mul_cnt - 1'b1;
               end else begin
                  cdb_q <= tag_q;
                  cdb_v <= mul_result;
               end
            end
            if ((state == DIV) && div_done) begin
               cdb_q <= tag_q;
               cdb_v <= div_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (XLEN=32, TAG_W=4, MUL_STAGES=2).
// Expected results and latencies are hand-computed constants.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic clk;
   logic rst;
   logic en;
   logic clear;
   int   checks;
   int   errors;

   mul_div_unit_if #(.XLEN(32), .TAG_W(4)) bus ();

   mul_div_unit #(
      .XLEN       (32),
      .TAG_W      (4),
      .MUL_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clear_i (clear),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed hang expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [3:0] tag,
                                input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (bus.rs_rdy_o !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (bus.rs_rdy_o !== 1'b1)
         checkOutput("issue_rdy", 64'(bus.rs_rdy_o), 64'd1);
      bus.rs_en_i = 1'b1;
      bus.rs_op_i = op;
      bus.rs_qd_i = tag;
      bus.rs_vs_i = a;
      bus.rs_vt_i = b;
      tick();
      bus.rs_en_i = 1'b0;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (bus.cdb_en_o !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   task automatic grantResult(input string name);
      bus.cdb_gnt_i = 1'b1;
      tick();
      bus.cdb_gnt_i = 1'b0;
      checkOutput({name, "_en_after_gnt"}, 64'(bus.cdb_en_o), 64'd0);
      checkOutput({name, "_rdy_after_gnt"}, 64'(bus.rs_rdy_o), 64'd1);
   endtask

   task automatic runOp(input string name, input logic [2:0] op, input logic [3:0] tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_val);
      int lat;
      applyStimulus(op, tag, a, b);
      waitResult(lat);
      checkOutput({name, "_lat"}, 64'(lat), 64'(exp_lat));
      checkOutput({name, "_val"}, 64'(bus.cdb_v_o), 64'(exp_val));
      checkOutput({name, "_tag"}, 64'(bus.cdb_q_o), 64'(tag));
      grantResult(name);
   endtask

   initial begin
      int lat;
      int seen;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      en            = 1'b1;
      clear         = 1'b0;
      bus.rs_en_i   = 1'b0;
      bus.rs_op_i   = 3'd0;
      bus.rs_qd_i   = 4'd0;
      bus.rs_vs_i   = 32'd0;
      bus.rs_vt_i   = 32'd0;
      bus.cdb_gnt_i = 1'b0;
      tick();
      tick();
      checkOutput("rst_rdy", 64'(bus.rs_rdy_o), 64'd1);
      checkOutput("rst_en", 64'(bus.cdb_en_o), 64'd0);
      checkOutput("rst_q", 64'(bus.cdb_q_o), 64'd0);
      checkOutput("rst_v", 64'(bus.cdb_v_o), 64'd0);
      rst = 1'b0;
      tick();

      $display("[TB] multiply vectors");
      runOp("mul",    MDU_MUL,    4'd5, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFEB);
      runOp("mulh",   MDU_MULH,   4'd1, 32'd7, 32'hFFFFFFFD, 2, 32'hFFFFFFFF);
      runOp("mulhu",  MDU_MULHU,  4'd2, 32'd7, 32'hFFFFFFFD, 2, 32'h00000006);
      runOp("mulhsu", MDU_MULHSU, 4'd3, 32'd7, 32'hFFFFFFFD, 2, 32'h00000006);

      $display("[TB] divide vectors");
      runOp("div",  MDU_DIV,  4'd4, 32'hFFFFFFEC, 32'd3, 33, 32'hFFFFFFFA);
      runOp("rem",  MDU_REM,  4'd6, 32'hFFFFFFEC, 32'd3, 33, 32'hFFFFFFFE);
      runOp("divu", MDU_DIVU, 4'd7, 32'hFFFFFFFF, 32'd2, 33, 32'h7FFFFFFF);

      $display("[TB] divide special cases");
      runOp("divu_by0", MDU_DIVU, 4'd8,  32'd5, 32'd0, 1, 32'hFFFFFFFF);
      runOp("remu_by0", MDU_REMU, 4'd9,  32'd5, 32'd0, 1, 32'd5);
      runOp("div_ovf",  MDU_DIV,  4'd10, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
      runOp("rem_ovf",  MDU_REM,  4'd11, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

      $display("[TB] hold until granted");
      applyStimulus(MDU_MULHU, 4'd9, 32'd7, 32'hFFFFFFFD);
      waitResult(lat);
      checkOutput("hold_lat", 64'(lat), 64'd2);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("hold_en", 64'(bus.cdb_en_o), 64'd1);
         checkOutput("hold_q", 64'(bus.cdb_q_o), 64'd9);
         checkOutput("hold_v", 64'(bus.cdb_v_o), 64'd6);
         checkOutput("hold_rdy", 64'(bus.rs_rdy_o), 64'd0);
      end
      grantResult("hold");

      $display("[TB] flush mid-divide");
      applyStimulus(MDU_DIV, 4'd3, 32'hFFFFFFEC, 32'd3);
      repeat (10) tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr_rdy", 64'(bus.rs_rdy_o), 64'd1);
      checkOutput("clr_en", 64'(bus.cdb_en_o), 64'd0);
      runOp("clr_mul", MDU_MUL, 4'd12, 32'd12, 32'd12, 2, 32'd144);
      seen = 0;
      repeat (40) begin
         tick();
         if (bus.cdb_en_o === 1'b1) seen++;
      end
      checkOutput("clr_no_stale", 64'(seen), 64'd0);

      $display("[TB] flush together with grant");
      applyStimulus(MDU_MUL, 4'd2, 32'd3, 32'd4);
      waitResult(lat);
      checkOutput("clrgnt_val", 64'(bus.cdb_v_o), 64'd12);
      clear         = 1'b1;
      bus.cdb_gnt_i = 1'b1;
      tick();
      clear         = 1'b0;
      bus.cdb_gnt_i = 1'b0;
      checkOutput("clrgnt_en", 64'(bus.cdb_en_o), 64'd0);
      checkOutput("clrgnt_rdy", 64'(bus.rs_rdy_o), 64'd1);
      seen = 0;
      repeat (10) begin
         tick();
         if (bus.cdb_en_o === 1'b1) seen++;
      end
      checkOutput("clrgnt_no_dup", 64'(seen), 64'd0);

      $display("[TB] stall mid-divide");
      applyStimulus(MDU_DIVU, 4'd7, 32'd100, 32'd7);
      repeat (5) tick();
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      waitResult(lat);
      checkOutput("stall_lat", 64'(lat + 10), 64'd38);
      checkOutput("stall_val", 64'(bus.cdb_v_o), 64'd14);
      checkOutput("stall_tag", 64'(bus.cdb_q_o), 64'd7);
      grantResult("stall");

      $display("[TB] async reset mid-multiply");
      applyStimulus(MDU_MUL, 4'd4, 32'd5, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_en", 64'(bus.cdb_en_o), 64'd0);
      checkOutput("arst_q", 64'(bus.cdb_q_o), 64'd0);
      checkOutput("arst_v", 64'(bus.cdb_v_o), 64'd0);
      checkOutput("arst_rdy", 64'(bus.rs_rdy_o), 64'd1);
      rst = 1'b0;
      tick();
      checkOutput("arst_idle_en", 64'(bus.cdb_en_o), 64'd0);
      runOp("arst_mul", MDU_MUL, 4'd13, 32'd6, 32'd7, 2, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
